// File: rtl/lfsr_byte_packer.sv
// lfsr_byte_packer: packs serial LFSR bits LSB-first into bytes, queues them in a FIFO and exposes them over Wishbone
module lfsr_byte_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_bit,
  input  logic       i_bit_valid,
  input  logic       i_wb_cyc,
  input  logic       i_wb_stb,
  input  logic       i_wb_we,
  input  logic [2:0] i_wb_addr,
  input  logic [7:0] i_wb_data,
  output logic       o_wb_stall,
  output logic       o_wb_ack,
  output logic [7:0] o_wb_data,
  output logic       o_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DEPTH = 4'(FIFO_DEPTH);
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0] count_q, count_d, thresh_q, thresh_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_q, byte_d, data_q, data_d;
  logic ack_q, ack_d, irq_q, irq_d, en_q, en_d, ovf_q, ovf_d, unf_q, unf_d;
  logic access, wr, ctrl_wr, sample, push, pop_req, pop, empty, full, push_ok, ovf_ev, flush, clr;
  logic [7:0] status, rd_data;
  logic unused;
  assign unused = ^i_wb_data[7:4];
  assign o_wb_stall = 1'b0;
  assign o_wb_ack = ack_q;
  assign o_wb_data = data_q;
  assign o_irq = irq_q;
  assign access = i_wb_cyc & i_wb_stb;
  assign wr = access & i_wb_we;
  assign ctrl_wr = wr & (i_wb_addr == 3'd2);
  assign flush = ctrl_wr & i_wb_data[1];
  assign clr = ctrl_wr & i_wb_data[2];
  assign sample = en_q & i_bit_valid;
  assign push = sample & (bit_cnt_q == 3'd7);
  assign empty = count_q == 4'd0;
  assign full = count_q == DEPTH;
  assign pop_req = access & ~i_wb_we & (i_wb_addr == 3'd0);
  assign pop = pop_req & ~empty;
  // a full FIFO still takes the new byte when a pop frees a slot in the same cycle
  assign push_ok = push & (~full | pop) & ~flush;
  assign ovf_ev = push & full & ~pop & ~flush;
  assign status = {ovf_q, unf_q, full, empty, count_q};
  assign rd_data = (i_wb_addr == 3'd0) ? (empty ? 8'h00 : mem_q[rd_ptr_q]) :
                   (i_wb_addr == 3'd1) ? status :
                   (i_wb_addr == 3'd2) ? {7'b0, en_q} :
                   (i_wb_addr == 3'd3) ? {4'b0, thresh_q} : 8'h00;
  // next-state for packer, FIFO, registers and bus response
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = {i_bit, byte_q[6:0]};
    byte_d = byte_q;
    if (sample) byte_d[bit_cnt_q] = i_bit;
    if (flush) byte_d = 8'h00;
    bit_cnt_d = flush ? 3'd0 : bit_cnt_q + 3'(sample);
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push_ok);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d = flush ? 4'd0 : count_q + 4'(push_ok) - 4'(pop);
    en_d = ctrl_wr ? i_wb_data[0] : en_q;
    thresh_d = (wr && i_wb_addr == 3'd3) ? i_wb_data[3:0] : thresh_q;
    ovf_d = ovf_ev | (ovf_q & ~clr);
    unf_d = (pop_req & empty) | (unf_q & ~clr);
    irq_d = (count_d >= thresh_d) | ovf_d;
    ack_d = access;
    data_d = (access && !i_wb_we) ? rd_data : 8'h00;
  end
  // state registers with asynchronous clear
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      thresh_q <= '0;
      bit_cnt_q <= '0;
      byte_q <= '0;
      data_q <= '0;
      ack_q <= 1'b0;
      irq_q <= 1'b0;
      en_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      thresh_q <= thresh_d;
      bit_cnt_q <= bit_cnt_d;
      byte_q <= byte_d;
      data_q <= data_d;
      ack_q <= ack_d;
      irq_q <= irq_d;
      en_q <= en_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
endmodule

// File: tb/tb_lfsr_byte_packer.sv
// tb_lfsr_byte_packer: directed and random checks of lfsr_byte_packer against a queue-based model
module tb_lfsr_byte_packer;
  localparam int D = 4;
  logic clk = 0, rst_n = 0, bit_i = 0, valid = 0, cyc = 0, stb = 0, we = 0;
  logic [2:0] addr = 0;
  logic [7:0] wdata = 0;
  logic stall, ack, irq;
  logic [7:0] rdata;
  int n_chk = 0, n_fail = 0;
  bit [7:0] mq[$];
  bit [7:0] pbyte;
  int nb;
  bit m_en, m_ovf, m_unf;
  bit [3:0] m_thr;

  always #5 clk = ~clk;

  lfsr_byte_packer #(.FIFO_DEPTH(D)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_bit(bit_i), .i_bit_valid(valid),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdata), .o_irq(irq)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    mq.delete(); pbyte = 0; nb = 0; m_en = 0; m_ovf = 0; m_unf = 0; m_thr = 0;
  endfunction

  function automatic void m_bit(input bit b);
    if (!m_en) return;
    pbyte[nb] = b;
    nb++;
    if (nb == 8) begin
      if (mq.size() < D) mq.push_back(pbyte); else m_ovf = 1;
      nb = 0;
    end
  endfunction

  function automatic bit [7:0] m_pop();
    if (mq.size() == 0) begin m_unf = 1; return 8'h00; end
    return mq.pop_front();
  endfunction

  function automatic void m_write(input bit [2:0] a, input bit [7:0] d);
    if (a == 2) begin
      if (d[1]) begin mq.delete(); nb = 0; pbyte = 0; end
      if (d[2]) begin m_ovf = 0; m_unf = 0; end
      m_en = d[0];
    end
    if (a == 3) m_thr = d[3:0];
  endfunction

  function automatic bit [7:0] m_status();
    return {m_ovf, m_unf, mq.size() == D, mq.size() == 0, 4'(mq.size())};
  endfunction

  function automatic bit m_irq();
    return (mq.size() >= int'(m_thr)) || m_ovf;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input bit b, input bit v);
    bit_i = b; valid = v;
    tick();
    valid = 0;
    if (v) m_bit(b);
    chk("ack_idle", ack, 0);
    chk("irq", irq, m_irq());
  endtask

  task automatic send_byte(input bit [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1);
  endtask

  task automatic wb_read(input bit [2:0] a, output bit [7:0] d);
    cyc = 1; stb = 1; we = 0; addr = a;
    tick();
    cyc = 0; stb = 0;
    chk("read_ack", ack, 1);
    d = rdata;
  endtask

  task automatic wb_write(input bit [2:0] a, input bit [7:0] d);
    cyc = 1; stb = 1; we = 1; addr = a; wdata = d;
    tick();
    cyc = 0; stb = 0; we = 0;
    chk("write_ack", ack, 1);
    m_write(a, d);
    chk("irq", irq, m_irq());
  endtask

  task automatic read_data(output bit [7:0] d);
    wb_read(0, d);
    chk("data", d, m_pop());
    chk("irq", irq, m_irq());
  endtask

  task automatic read_status(output bit [7:0] d);
    wb_read(1, d);
    chk("status", d, m_status());
    chk("irq", irq, m_irq());
  endtask

  task automatic bit_and_read(input bit b, output bit [7:0] d);
    bit [7:0] e;
    bit_i = b; valid = 1; cyc = 1; stb = 1; we = 0; addr = 0;
    tick();
    valid = 0; cyc = 0; stb = 0;
    chk("combo_ack", ack, 1);
    e = m_pop();
    m_bit(b);
    d = rdata;
    chk("combo_data", d, e);
    chk("irq", irq, m_irq());
  endtask

  initial begin
    bit [7:0] d, v;
    bit [7:0] pat;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_data", rdata, 0);
    chk("rst_irq", irq, 0);
    chk("stall", stall, 0);
    rst_n = 1;
    read_status(d);
    chk("reset_status", d, 8'h10);
    // packing
    wb_write(2, 8'h01);
    pat = 8'b1000_1101;
    for (int i = 0; i < 8; i++) send_bit(pat[i], 1);
    read_status(d);
    chk("pack_status", d, 8'h01);
    read_data(d);
    chk("pack_data", d, 8'h8D);
    read_status(d);
    chk("pack_status_after", d, 8'h10);
    // overflow
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    read_status(d);
    chk("ovf_status", d, 8'hA4);
    chk("ovf_irq", irq, 1);
    for (int i = 1; i <= 4; i++) begin
      read_data(d);
      chk("ovf_data", d, 8'(i));
    end
    // underflow
    wb_write(2, 8'h05);
    read_status(d);
    chk("clr_status", d, 8'h10);
    read_data(d);
    chk("unf_data", d, 8'h00);
    read_status(d);
    chk("unf_status", d, 8'h50);
    wb_write(2, 8'h05);
    read_status(d);
    chk("unf_clr_status", d, 8'h10);
    // simultaneous push and pop on a full FIFO
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i));
    v = 8'h55;
    for (int i = 0; i < 7; i++) send_bit(v[i], 1);
    bit_and_read(v[7], d);
    chk("pp_data", d, 8'h11);
    read_status(d);
    chk("pp_status", d, 8'h24);
    for (int i = 0; i < 4; i++) read_data(d);
    chk("pp_last", d, 8'h55);
    // push and pop on an empty FIFO
    for (int i = 0; i < 7; i++) send_bit(v[i], 1);
    bit_and_read(v[7], d);
    read_status(d);
    chk("pp_empty_status", d, 8'h41);
    read_data(d);
    wb_write(2, 8'h05);
    // flush
    send_byte(8'h3C);
    send_byte(8'h7E);
    for (int i = 0; i < 3; i++) send_bit(1, 1);
    wb_write(2, 8'h03);
    read_status(d);
    chk("flush_status", d, 8'h10);
    send_byte(8'hC5);
    read_data(d);
    chk("flush_data", d, 8'hC5);
    // enable gating holds the partial byte
    v = 8'hA3;
    for (int i = 0; i < 4; i++) send_bit(v[i], 1);
    wb_write(2, 8'h00);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1);
    wb_write(2, 8'h01);
    for (int i = 4; i < 8; i++) send_bit(v[i], 1);
    read_data(d);
    chk("hold_data", d, 8'hA3);
    // threshold interrupt
    wb_write(3, 8'hF2);
    wb_read(3, d);
    chk("thresh_rd", d, 8'h02);
    send_byte(8'h01);
    chk("thr_irq_lo", irq, 0);
    send_byte(8'h02);
    chk("thr_irq_hi", irq, 1);
    for (int a = 4; a < 8; a++) begin
      wb_write(3'(a), 8'hFF);
      wb_read(3'(a), d);
      chk("unmapped", d, 8'h00);
    end
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3, 4: send_bit(1'($urandom), $urandom_range(0, 4) != 0);
        5: read_data(d);
        6: read_status(d);
        7: begin
          d = 8'($urandom);
          d[1] = ($urandom_range(0, 7) == 0);
          d[0] = ($urandom_range(0, 3) != 0);
          wb_write(2, d);
        end
        8: wb_write(3, 8'($urandom));
        9: bit_and_read(1'($urandom), d);
        10: begin
          wb_read(2, d);
          chk("ctrl_rd", d, {7'b0, m_en});
        end
        default: begin
          wb_read(3, d);
          chk("thresh_rd", d, {4'b0, m_thr});
        end
      endcase
    end
    // asynchronous reset between edges, with an access held through reset
    wb_write(2, 8'h05);
    wb_write(3, 8'h00);
    for (int i = 0; i < 3; i++) send_bit(1, 1);
    cyc = 1; stb = 1; we = 0; addr = 1;
    tick();
    chk("pre_rst_ack", ack, 1);
    chk("pre_rst_irq", irq, 1);
    #2 rst_n = 0;
    #1;
    chk("async_ack", ack, 0);
    chk("async_data", rdata, 0);
    chk("async_irq", irq, 0);
    tick();
    chk("ack_in_reset", ack, 0);
    cyc = 0; stb = 0;
    rst_n = 1;
    m_reset();
    tick();
    chk("ack_after_release", ack, 0);
    read_status(d);
    chk("post_rst_status", d, 8'h10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
